stream_arbiter_mux: RTL and testbench

Registered N-to-1 streaming multiplexer with a valid/ready handshake on every channel and built-in arbitration. It replaces an externally selected combinational mux wherever several producers share one consumer.
- Grant is held for a whole packet, delimited by a per-channel last flag.
- One output register stage decouples the consumer.
- Sits between producer units and shared downstream logic in the same datapath.

---
 rtl/stream_arbiter_mux_pkg.sv | 28 ++
 rtl/stream_arbiter_pick.sv | 47 ++++
 rtl/stream_arbiter_mux.sv | 196 +++++++++++++++++++
 tb/tb_stream_arbiter_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arbiter_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_arbiter_mux_pkg
//  Description : Shared definitions for the streaming arbiter/multiplexer.
//                Holds the arbitration-mode constants, the packet state enum
//                and a helper that locates a channel slice inside a
//                flattened bus.
//  Revision    : 1.0  initial release
// ============================================================================
package stream_arbiter_mux_pkg;

    // Arbitration policy selectors
    localparam int MODE_FIXED = 0;  // lowest requesting index wins
    localparam int MODE_RR    = 1;  // rotating priority starting at rr pointer

    // Packet-level state: IDLE arbitrates per packet, BUSY holds the grant
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Lowest bit position of channel idx in a bus of width-bit slices
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage : stream_arbiter_mux_pkg
`default_nettype wire

// File: rtl/stream_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : stream_arbiter_pick
//  Description : Combinational request picker. Returns the index of the
//                winning request and a flag saying whether any request is
//                active.
//                  i_mode = 0 : lowest set index wins
//                  i_mode = 1 : first set index searching upward from i_ptr,
//                               wrapping from N-1 back to 0
//  Ports       : i_req    [N-1:0]      request vector
//                i_ptr    [IDX_W-1:0]  rotating search start
//                i_mode                arbitration policy
//                o_winner [IDX_W-1:0]  winning index (0 when no request)
//                o_any                 at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module stream_arbiter_pick #(
    parameter int IDX_W = 2,
    localparam int N    = 2 ** IDX_W
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_mode,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_winner = '0;
        o_any    = |i_req;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            // The IDX_W-bit sum wraps naturally, giving the circular search.
            w_idx = i_mode ? (i_ptr + IDX_W'(k)) : IDX_W'(k);
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

endmodule : stream_arbiter_pick
`default_nettype wire

// File: rtl/stream_arbiter_mux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_arbiter_mux
//  Description : Registered N-to-1 streaming multiplexer with valid/ready
//                handshakes and packet-granular arbitration. A grant, once
//                given, is held until the granted channel delivers a beat
//                with its last flag set. A single output register stage
//                decouples the downstream consumer; throughput is one beat
//                per cycle while QR is high.
//  Options     : `define STREAM_ARBITER_MUX_STATS_EN adds port BC with one
//                16-bit wrapping completed-packet counter per channel.
//  Ports       : clk  clock, rising edge
//                rst  synchronous active-high reset
//                D    [WIDTH*N-1:0] flattened channel data
//                V    [N-1:0]       per-channel valid
//                L    [N-1:0]       per-channel last-beat flag
//                R    [N-1:0]       per-channel ready (combinational, one-hot)
//                Q    [WIDTH-1:0]   registered output data
//                QV                 output valid
//                QL                 output last flag
//                QS   [ADDRESS_SIZE-1:0] source channel of Q
//                QR                 downstream ready
//                BC   [16*N-1:0]    per-channel packet counters (option)
//  Revision    : 1.0  initial release
// ============================================================================
module stream_arbiter_mux
    import stream_arbiter_mux_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDRESS_SIZE = 2,
    parameter int MODE         = MODE_RR,
    localparam int N           = 2 ** ADDRESS_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH*N-1:0]      D,
    input  logic [N-1:0]            V,
    input  logic [N-1:0]            L,
    output logic [N-1:0]            R,
    output logic [WIDTH-1:0]        Q,
    output logic                    QV,
    output logic                    QL,
    output logic [ADDRESS_SIZE-1:0] QS,
    input  logic                    QR
`ifdef STREAM_ARBITER_MUX_STATS_EN
    ,
    output logic [16*N-1:0]         BC
`endif
);

    localparam logic c_rr_en = (MODE == MODE_RR);
    localparam logic [ADDRESS_SIZE-1:0] c_one = ADDRESS_SIZE'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  r_state_q,  w_state_d;
    logic [ADDRESS_SIZE-1:0] r_grant_q,  w_grant_d;   // latched while BUSY
    logic [ADDRESS_SIZE-1:0] r_rr_q,     w_rr_d;      // round-robin start
    logic [WIDTH-1:0]        r_data_q,   w_data_d;
    logic                    r_valid_q,  w_valid_d;
    logic                    r_last_q,   w_last_d;
    logic [ADDRESS_SIZE-1:0] r_src_q,    w_src_d;

    // ------------------------------------------------------------------
    // Arbitration and source selection
    // ------------------------------------------------------------------
    logic [ADDRESS_SIZE-1:0] w_pick;
    logic                    w_any;
    logic [ADDRESS_SIZE-1:0] w_grant;
    logic                    w_space;
    logic                    w_offer;
    logic                    w_src_valid;
    logic                    w_accept;
    logic [WIDTH-1:0]        w_sel_data;
    logic                    w_sel_last;

    stream_arbiter_pick #(
        .IDX_W    (ADDRESS_SIZE)
    ) u_pick (
        .i_req    (V),
        .i_ptr    (r_rr_q),
        .i_mode   (c_rr_en),
        .o_winner (w_pick),
        .o_any    (w_any)
    );

    always_comb begin
        // Output slot is free when empty or being drained this cycle.
        w_space = ~r_valid_q | QR;
        w_grant = (r_state_q == BUSY) ? r_grant_q : w_pick;
        // In IDLE with no requests nobody is offered ready; in BUSY the
        // locked channel is offered ready whether or not it is valid.
        w_offer = w_space & ~rst & ((r_state_q == BUSY) | w_any);

        R           = '0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        w_src_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ADDRESS_SIZE'(i) == w_grant) begin
                R[i]        = w_offer;
                w_sel_data  = D[slice_lo(i, WIDTH) +: WIDTH];
                w_sel_last  = L[i];
                w_src_valid = V[i];
            end
        end
        w_accept = w_src_valid & w_offer;
    end

    // ------------------------------------------------------------------
    // Next-state and output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_rr_d    = r_rr_q;
        w_data_d  = r_data_q;
        w_last_d  = r_last_q;
        w_src_d   = r_src_q;
        w_valid_d = r_valid_q;

        if (w_accept) begin
            // Load takes priority; a simultaneous drain keeps QV high.
            w_data_d  = w_sel_data;
            w_last_d  = w_sel_last;
            w_src_d   = w_grant;
            w_valid_d = 1'b1;
            if (w_sel_last) begin
                w_state_d = IDLE;
                if (c_rr_en) begin
                    w_rr_d = w_grant + c_one;
                end
            end else begin
                w_state_d = BUSY;
                w_grant_d = w_grant;
            end
        end else if (QR) begin
            // Drained with nothing new: only valid drops, payload holds.
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_grant_q <= '0;
            r_rr_q    <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_src_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_rr_q    <= w_rr_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_last_q  <= w_last_d;
            r_src_q   <= w_src_d;
        end
    end

    assign Q  = r_data_q;
    assign QV = r_valid_q;
    assign QL = r_last_q;
    assign QS = r_src_q;

`ifdef STREAM_ARBITER_MUX_STATS_EN
    // ------------------------------------------------------------------
    // Completed-packet counters, one per channel, wrapping at 16 bits
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_stats
        logic [15:0] r_bc_q, w_bc_d;

        always_comb begin
            w_bc_d = r_bc_q;
            if (w_accept && w_sel_last && (w_grant == ADDRESS_SIZE'(g))) begin
                w_bc_d = r_bc_q + 16'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_bc_q <= '0;
            end else begin
                r_bc_q <= w_bc_d;
            end
        end

        assign BC[g*16 +: 16] = r_bc_q;
    end
`endif

endmodule : stream_arbiter_mux
`default_nettype wire

// File: tb/tb_stream_arbiter_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_arbiter_mux
//  Description : Directed self-checking bench. One round-robin instance and
//                one fixed-priority instance share the clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_arbiter_mux;

    logic        clk = 1'b0;
    logic        rst;

    // Round-robin instance
    logic [31:0] d;
    logic [3:0]  v, l, r;
    logic [7:0]  q;
    logic        qv, ql, qr;
    logic [1:0]  qs;

    // Fixed-priority instance
    logic [31:0] f_d;
    logic [3:0]  f_v, f_l, f_r;
    logic [7:0]  f_q;
    logic        f_qv, f_ql, f_qr;
    logic [1:0]  f_qs;

`ifdef STREAM_ARBITER_MUX_STATS_EN
    logic [63:0] bc, f_bc;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_arbiter_mux #(.WIDTH(8), .ADDRESS_SIZE(2), .MODE(1)) u_dut_rr (
        .clk (clk), .rst (rst), .D (d), .V (v), .L (l), .R (r),
        .Q (q), .QV (qv), .QL (ql), .QS (qs), .QR (qr)
`ifdef STREAM_ARBITER_MUX_STATS_EN
        , .BC (bc)
`endif
    );

    stream_arbiter_mux #(.WIDTH(8), .ADDRESS_SIZE(2), .MODE(0)) u_dut_fx (
        .clk (clk), .rst (rst), .D (f_d), .V (f_v), .L (f_l), .R (f_r),
        .Q (f_q), .QV (f_qv), .QL (f_ql), .QS (f_qs), .QR (f_qr)
`ifdef STREAM_ARBITER_MUX_STATS_EN
        , .BC (f_bc)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge; registered outputs settle by then.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        d    = 32'hA3A2A1A0;
        v    = 4'b1111;
        l    = 4'b1111;
        qr   = 1'b1;
        f_d  = 32'hB3B2B1B0;
        f_v  = 4'b0000;
        f_l  = 4'b1111;
        f_qr = 1'b1;

        // ---------------- reset / idle ----------------
        #1;
        check_value("rst_r0", {28'd0, r}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_value("rst_r", {28'd0, r}, 32'd0);
        end
        check_value("rst_qv", {31'd0, qv}, 32'd0);
        check_value("rst_q",  {24'd0, q},  32'd0);
        check_value("rst_qs", {30'd0, qs}, 32'd0);
        check_value("rst_fqv", {31'd0, f_qv}, 32'd0);
        rst = 1'b0;
        v   = 4'b0000;
        #1;
        check_value("idle_r", {28'd0, r}, 32'd0);
        tick();
        check_value("idle_qv", {31'd0, qv}, 32'd0);

        // ---------------- round robin, single-beat packets ----------------
        v = 4'b1111;
        l = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_value("rr_r", {28'd0, r}, 32'd1 << (k % 4));
            tick();
            check_value("rr_qs", {30'd0, qs}, 32'(k % 4));
            check_value("rr_q",  {24'd0, q},  32'h0A0 + 32'(k % 4));
            check_value("rr_qv", {31'd0, qv}, 32'd1);
        end
        v = 4'b0000;
        #1;
        check_value("drain_r", {28'd0, r}, 32'd0);
        tick();
        check_value("drain_qv", {31'd0, qv}, 32'd0);
        check_value("drain_qs", {30'd0, qs}, 32'd0);
        check_value("drain_q",  {24'd0, q},  32'hA0);

        // ---------------- packet lock on channel 2 ----------------
        v = 4'b0010;                       // ch1 alone moves pointer to 2
        #1;
        check_value("pre_r", {28'd0, r}, 32'b0010);
        tick();
        check_value("pre_qs", {30'd0, qs}, 32'd1);

        v = 4'b0111;
        l = 4'b1011;
        d[23:16] = 8'hC0;
        #1;
        check_value("lock_r0", {28'd0, r}, 32'b0100);
        tick();
        check_value("lock_q0",  {24'd0, q},  32'hC0);
        check_value("lock_ql0", {31'd0, ql}, 32'd0);
        check_value("lock_qs0", {30'd0, qs}, 32'd2);
        d[23:16] = 8'hC1;
        #1;
        check_value("lock_r1", {28'd0, r}, 32'b0100);
        tick();
        check_value("lock_q1", {24'd0, q}, 32'hC1);
        d[23:16] = 8'hC2;
        l = 4'b1111;
        #1;
        check_value("lock_r2", {28'd0, r}, 32'b0100);
        tick();
        check_value("lock_q2",  {24'd0, q},  32'hC2);
        check_value("lock_ql2", {31'd0, ql}, 32'd1);

        v = 4'b1011;                       // pointer now 3
        #1;
        check_value("post_r3", {28'd0, r}, 32'b1000);
        tick();
        check_value("post_qs3", {30'd0, qs}, 32'd3);
        v = 4'b0011;                       // pointer wrapped to 0
        #1;
        check_value("post_r0", {28'd0, r}, 32'b0001);
        tick();
        check_value("post_qs0", {30'd0, qs}, 32'd0);
        check_value("post_q0",  {24'd0, q},  32'hA0);

        // ---------------- backpressure ----------------
        qr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_value("bp_r", {28'd0, r}, 32'd0);
            tick();
            check_value("bp_qv", {31'd0, qv}, 32'd1);
            check_value("bp_q",  {24'd0, q},  32'hA0);
            check_value("bp_qs", {30'd0, qs}, 32'd0);
            check_value("bp_ql", {31'd0, ql}, 32'd1);
        end
        qr = 1'b1;
        #1;
        check_value("bp_rel_r", {28'd0, r}, 32'b0010);
        tick();
        check_value("bp_rel_qv", {31'd0, qv}, 32'd1);
        check_value("bp_rel_qs", {30'd0, qs}, 32'd1);
        check_value("bp_rel_q",  {24'd0, q},  32'hA1);

        // ---------------- reset in the middle of a packet ----------------
        v = 4'b0010;
        l = 4'b1101;
        #1;
        check_value("mid_r", {28'd0, r}, 32'b0010);
        tick();
        check_value("mid_ql", {31'd0, ql}, 32'd0);
        rst = 1'b1;
        v   = 4'b0000;
        #1;
        check_value("mid_rst_r", {28'd0, r}, 32'd0);
        tick();
        rst = 1'b0;
        check_value("mid_qv", {31'd0, qv}, 32'd0);
        check_value("mid_q",  {24'd0, q},  32'd0);
        check_value("mid_qs", {30'd0, qs}, 32'd0);
`ifdef STREAM_ARBITER_MUX_STATS_EN
        check_value("mid_bc_lo", bc[31:0],  32'd0);
        check_value("mid_bc_hi", bc[63:32], 32'd0);
`endif
        v = 4'b0101;
        l = 4'b1111;
        #1;
        check_value("mid_after_r", {28'd0, r}, 32'b0001);
        tick();
        check_value("mid_after_qs", {30'd0, qs}, 32'd0);
`ifdef STREAM_ARBITER_MUX_STATS_EN
        check_value("bc_ch0", {16'd0, bc[15:0]}, 32'd1);
`endif
        v = 4'b0000;

        // ---------------- fixed priority ----------------
        f_v = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_value("fx_r1", {28'd0, f_r}, 32'b0010);
            tick();
            check_value("fx_qs1", {30'd0, f_qs}, 32'd1);
            check_value("fx_q1",  {24'd0, f_q},  32'hB1);
        end
        f_v = 4'b1000;
        #1;
        check_value("fx_r3", {28'd0, f_r}, 32'b1000);
        tick();
        check_value("fx_qs3", {30'd0, f_qs}, 32'd3);
        check_value("fx_q3",  {24'd0, f_q},  32'hB3);
        f_v = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stream_arbiter_mux
`default_nettype wire
